// File: rtl/wb_memtest_master_if.sv
// Wishbone B4 bus bundle shared by the memory test master and its responder.
// Carries clock and synchronous reset alongside the handshake signals.
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    input  clk, rst, ack, err, rty, dat_sm,
    output cyc, stb, we, sel, adr, dat_ms, cti, bte
  );

  modport slave (
    input  clk, rst, cyc, stb, we, sel, adr, dat_ms, cti, bte,
    output ack, err, rty, dat_sm
  );
endinterface

// File: rtl/wb_memtest_master.sv
// Wishbone memory test master: writes a pattern to N_WORDS words, reads back.
// Define MEMTEST_BURST_EN to run the read phase as incrementing bursts.
module wb_memtest_master #(
  parameter int          N_WORDS   = 2048,
  parameter logic [31:0] BASE_ADR  = 32'h0,
  parameter int          BURST_LEN = 4
) (
  wshb_if.master      wb_m,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_err_adr
);
  localparam int IW = $clog2(N_WORDS + 1);
  localparam logic [IW-1:0] LAST = IW'(N_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d, i_inc;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [2:0]    cti_q, cti_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [31:0]   fadr_q, fadr_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          ack_ok;
`ifdef MEMTEST_BURST_EN
  logic [4:0]    beats_q, beats_d;
  logic [4:0]    first_beats;
  logic [IW-1:0] rem;
`endif

  function automatic logic [31:0] word_adr(input logic [IW-1:0] k);
    return BASE_ADR + (32'(k) << 2);
  endfunction

  function automatic logic [31:0] pattern(input logic [IW-1:0] k);
    logic [15:0] lo;
    lo = 16'(k);
    return {~lo, lo};
  endfunction

  assign i_inc  = i_q + 1'b1;
  // A retry response never completes the access.
  assign ack_ok = wb_m.ack & ~wb_m.rty;

`ifdef MEMTEST_BURST_EN
  assign rem         = IW'(N_WORDS) - i_q;
  assign first_beats = (32'(rem) < 32'(BURST_LEN)) ?
                       5'(rem) : 5'(BURST_LEN);
`endif

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cti_d   = cti_q;
    cnt_d   = cnt_q;
    fadr_d  = fadr_q;
    done_d  = done_q;
    pass_d  = pass_q;
`ifdef MEMTEST_BURST_EN
    beats_d = beats_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WRITE;
          i_d     = '0;
          cnt_d   = '0;
          fadr_d  = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          sel_d   = 4'hF;
          cti_d   = 3'b000;
          adr_d   = word_adr('0);
          dat_d   = pattern('0);
        end
      end
      WRITE: begin
        if (wb_m.err) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end else if (ack_ok) begin
          if (i_q == LAST) begin
            state_d = READ;
            i_d     = '0;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            adr_d   = word_adr('0);
          end else begin
            i_d   = i_inc;
            adr_d = word_adr(i_inc);
            dat_d = pattern(i_inc);
          end
        end
      end
      READ: begin
        if (!stb_q) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
`ifdef MEMTEST_BURST_EN
          beats_d = first_beats;
          cti_d   = (first_beats == 5'd1) ? 3'b111 : 3'b010;
`else
          cti_d = 3'b000;
`endif
        end else if (wb_m.err) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          cti_d   = 3'b000;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end else if (ack_ok) begin
          if (wb_m.dat_sm != pattern(i_q)) begin
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            if (cnt_q == 16'h0) fadr_d = adr_q;
          end
          if (i_q == LAST) begin
            state_d = DONE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            cti_d   = 3'b000;
            done_d  = 1'b1;
            pass_d  = (cnt_d == 16'h0);
          end else begin
            i_d   = i_inc;
            adr_d = word_adr(i_inc);
`ifdef MEMTEST_BURST_EN
            if (beats_q == 5'd1) begin
              cyc_d = 1'b0;
              stb_d = 1'b0;
              cti_d = 3'b000;
            end else begin
              beats_d = beats_q - 5'd1;
              cti_d   = (beats_q == 5'd2) ? 3'b111 : 3'b010;
            end
`else
            cyc_d = 1'b0;
            stb_d = 1'b0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_m.clk) begin
    if (wb_m.rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= 32'h0;
      dat_q   <= 32'h0;
      cti_q   <= 3'b000;
      cnt_q   <= 16'h0;
      fadr_q  <= 32'h0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef MEMTEST_BURST_EN
      beats_q <= 5'd0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cti_q   <= cti_d;
      cnt_q   <= cnt_d;
      fadr_q  <= fadr_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef MEMTEST_BURST_EN
      beats_q <= beats_d;
`endif
    end
  end

  assign wb_m.cyc    = cyc_q;
  assign wb_m.stb    = stb_q;
  assign wb_m.we     = we_q;
  assign wb_m.sel    = sel_q;
  assign wb_m.adr    = adr_q;
  assign wb_m.dat_ms = dat_q;
  assign wb_m.cti    = cti_q;
  assign wb_m.bte    = 2'b00;

  assign busy          = (state_q == WRITE) || (state_q == READ);
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = cnt_q;
  assign first_err_adr = fadr_q;
endmodule

// File: tb/tb_wb_memtest_master.sv
// Bench for wb_memtest_master: random-latency memory responder with
// per-word corruption, error injection, reset and restart scenarios.
module tb_wb_memtest_master;
  localparam int          N    = 10;
  localparam logic [31:0] BASE = 32'h100;
  localparam int          BL   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] first_err_adr;

  wshb_if bus (.clk(clk), .rst(rst));

  wb_memtest_master #(
    .N_WORDS(N), .BASE_ADR(BASE), .BURST_LEN(BL)
  ) dut (
    .wb_m(bus),
    .start(start),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .first_err_adr(first_err_adr)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [2048];
  logic [31:0] corrupt [N];
  int          err_word = -1;
  int          wr_acks, rd_acks, viol;
  logic [2:0]  ctis [$];
  int          n_vec = 0;
  int          n_miss = 0;

  // Memory responder and protocol monitor, one step per falling edge.
  initial begin
    logic        p_stb, p_we, p_ack, p_err;
    logic [31:0] p_adr, p_dat;
    logic [2:0]  p_cti;
    int          k, r;
    bus.ack = 1'b0; bus.err = 1'b0; bus.rty = 1'b0; bus.dat_sm = 32'h0;
    p_stb = 1'b0; p_we = 1'b0; p_ack = 1'b0; p_err = 1'b0;
    p_adr = 32'h0; p_dat = 32'h0; p_cti = 3'b000;
    forever begin
      @(negedge clk);
      if (p_stb && p_ack) begin
        if (p_we) wr_acks++;
        else begin
          rd_acks++;
          ctis.push_back(p_cti);
        end
      end
      if (p_stb && bus.stb && !p_ack && !p_err &&
          (bus.adr != p_adr || bus.we != p_we ||
           (p_we && bus.dat_ms != p_dat)))
        viol++;
      if (p_stb && p_we && bus.stb && !bus.we) viol++;
      if (p_stb && p_err && bus.cyc) viol++;
`ifdef MEMTEST_BURST_EN
      if (p_stb && p_ack && !p_we && p_cti == 3'b111 && bus.stb) viol++;
`else
      if (p_stb && p_ack && !p_we && bus.stb) viol++;
`endif
      bus.ack = 1'b0; bus.err = 1'b0; bus.rty = 1'b0;
      if (bus.cyc && bus.stb && !rst) begin
        k = int'((bus.adr - BASE) >> 2);
        r = int'($urandom_range(0, 9));
        if (bus.we && k == err_word) bus.err = 1'b1;
        else if (r == 2) bus.rty = 1'b1;
        else if (r > 2) begin
          bus.ack = 1'b1;
          if (bus.we) mem[bus.adr[12:2]] = bus.dat_ms;
          else bus.dat_sm = mem[bus.adr[12:2]] ^
                            ((k >= 0 && k < N) ? corrupt[k] : 32'h0);
        end
      end
      p_stb = bus.cyc && bus.stb;
      p_we  = bus.we;
      p_adr = bus.adr;
      p_dat = bus.dat_ms;
      p_cti = bus.cti;
      p_ack = bus.ack;
      p_err = bus.err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    @(negedge clk);
    #1;
    wr_acks = 0;
    rd_acks = 0;
    viol    = 0;
    ctis.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (!done && c < 3000) begin
      @(negedge clk);
      c++;
    end
    #1;
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic full_run(input string tag);
    int          ecnt, bad, cbad;
    logic [31:0] efa;
    logic [2:0]  ecti;
    ecnt = 0;
    efa  = 32'h0;
    for (int k = 0; k < N; k++)
      if (corrupt[k] != 32'h0) begin
        if (ecnt == 0) efa = BASE + 32'(4 * k);
        ecnt++;
      end
    clear_counts();
    pulse_start();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(tag);
    chk({tag, "_pass"}, 32'(pass), 32'(ecnt == 0));
    chk({tag, "_errcnt"}, 32'(err_count), 32'(ecnt));
    chk({tag, "_first"}, first_err_adr, efa);
    chk({tag, "_wracks"}, 32'(wr_acks), 32'(N));
    chk({tag, "_rdacks"}, 32'(rd_acks), 32'(N));
    chk({tag, "_proto"}, 32'(viol), 32'd0);
    bad = 0;
    for (int k = 0; k < N; k++)
      if (mem[(BASE >> 2) + 32'(k)] !== {~16'(k), 16'(k)}) bad++;
    chk({tag, "_memimg"}, 32'(bad), 32'd0);
    cbad = 0;
    for (int k = 0; k < ctis.size() && k < N; k++) begin
`ifdef MEMTEST_BURST_EN
      ecti = ((k % BL) == BL - 1 || k == N - 1) ? 3'b111 : 3'b010;
`else
      ecti = 3'b000;
`endif
      if (ctis[k] !== ecti) cbad++;
    end
    chk({tag, "_cti"}, 32'(cbad), 32'd0);
  endtask

  initial begin
    int c;
    for (int k = 0; k < 2048; k++) mem[k] = $urandom;
    for (int k = 0; k < N; k++) corrupt[k] = 32'h0;
    wr_acks = 0; rd_acks = 0; viol = 0;

    repeat (3) @(negedge clk);
    chk("rst_ctl", {29'h0, bus.cyc, bus.stb, bus.we}, 32'h0);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_cti_bte", {27'h0, bus.cti, bus.bte}, 32'h0);
    chk("rst_adr", bus.adr, 32'h0);
    chk("rst_dat", bus.dat_ms, 32'h0);
    chk("rst_flags", {29'h0, busy, done, pass}, 32'h0);
    chk("rst_errcnt", 32'(err_count), 32'h0);
    chk("rst_first", first_err_adr, 32'h0);
    rst = 1'b0;

    full_run("clean");
    repeat (5) @(negedge clk);
    chk("done_hold", {30'h0, done, busy}, 32'h2);

    corrupt[5] = 32'h1;
    full_run("bit0_w5");
    corrupt[5] = 32'h0;

    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < N; k++)
        corrupt[k] = ($urandom_range(0, 2) == 0) ?
                     ($urandom | (32'h1 << $urandom_range(0, 31))) : 32'h0;
      full_run($sformatf("rand%0d", t));
    end

    for (int k = 0; k < N; k++) corrupt[k] = 32'h1 << k;
    full_run("allbad");
    for (int k = 0; k < N; k++) corrupt[k] = 32'h0;

    err_word = 3;
    clear_counts();
    pulse_start();
    wait_done("wrerr");
    chk("wrerr_pass", 32'(pass), 32'd0);
    chk("wrerr_wracks", 32'(wr_acks), 32'd3);
    chk("wrerr_rdacks", 32'(rd_acks), 32'd0);
    chk("wrerr_proto", 32'(viol), 32'd0);
    chk("wrerr_busy", 32'(busy), 32'd0);
    err_word = -1;

    clear_counts();
    pulse_start();
    c = 0;
    while (!(bus.stb && !bus.we && bus.adr == BASE + 32'd8) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("midrd_reach", 32'(bus.adr), BASE + 32'd8);
    rst = 1'b1;
    @(negedge clk);
    chk("midrd_rst", {28'h0, bus.cyc, bus.stb, busy, done}, 32'h0);
    rst = 1'b0;
    full_run("rerun");

    clear_counts();
    pulse_start();
    c = 0;
    while (wr_acks < 5 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("restart_reach", 32'(wr_acks >= 5), 32'd1);
    pulse_start();
    wait_done("restart");
    chk("restart_wracks", 32'(wr_acks), 32'(N));
    chk("restart_rdacks", 32'(rd_acks), 32'(N));
    chk("restart_pass", 32'(pass), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/wb_memtest_master.md
WB_MEMTEST_MASTER -- requirements
Module: wb_memtest_master

Interface
REQ-001 SHALL have parameter N_WORDS, default 2048, meaning the number of 32-bit words tested (1..65536).
REQ-002 SHALL have parameter BASE_ADR, default 0, meaning the byte address of the first word (multiple of 4).
REQ-003 SHALL have parameter BURST_LEN, default 4, meaning beats per read burst (1..16).
REQ-004 SHALL use one clock and a synchronous, active-high reset: wb_m.clk  input  1  clock; wb_m.rst  input  1  synchronous active-high reset.
REQ-005 SHALL expose wb_m  wshb_if.master  -  Wishbone initiator (cyc, stb, we, sel, adr, dat_ms, cti, bte out; ack, err, rty, dat_sm in).
REQ-006 SHALL have start  input  1  single-cycle request to run one test.
REQ-007 SHALL have busy  output  1  high from the start acceptance through the end of the read phase.
REQ-008 SHALL have done  output  1  held high after a run completes, until the next start.
REQ-009 SHALL have pass  output  1  valid when done is high; 1 means zero mismatches and no bus error.
REQ-010 SHALL have err_count  output  16  number of mismatching words, saturating at 16'hFFFF.
REQ-011 SHALL have first_err_adr  output  32  byte address of the first mismatch; 0 if there is none.

Function
REQ-012 SHALL implement the states IDLE, WRITE, READ and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL move the block to WRITE on the next edge, clear err_count, first_err_adr, done and pass, and zero the word index i.
REQ-014 A start pulse while in WRITE or READ SHALL be ignored.
REQ-015 WRITE SHALL issue classic single writes with cyc=stb=we=1, sel=4'hF, cti=3'b000, bte=2'b00, adr=BASE_ADR+4*i, dat_ms={~i[15:0], i[15:0]}.
REQ-016 In WRITE, adr, dat_ms and stb SHALL stay stable until ack.
REQ-017 In WRITE, i SHALL increment on each ack cycle.
REQ-018 On the ack for i=N_WORDS-1 in WRITE, the block SHALL zero i and enter READ.
REQ-019 cyc and stb SHALL drop for at least one cycle between the write and read phases.
REQ-020 READ SHALL issue we=0 cycles with sel=4'hF and adr=BASE_ADR+4*i.
REQ-021 In READ, adr SHALL advance by 4 in the cycle following each ack.
REQ-022 In READ, dat_sm SHALL be sampled on each ack cycle and compared to {~i[15:0], i[15:0]}.
REQ-023 On a READ mismatch, err_count SHALL increment unless saturated.
REQ-024 On the first READ mismatch, first_err_adr SHALL capture that word's byte address.
REQ-025 After the ack for i=N_WORDS-1 in READ, the block SHALL drop cyc/stb, go to DONE, and set done=1 and pass=(err_count==0 and no err seen).
REQ-026 A wb_m.err=1 on any cycle with stb high SHALL end the cycle, drop cyc/stb next edge, and go to DONE with pass=0; that word's data SHALL be ignored.
REQ-027 rty SHALL be treated as not-ack: stb stays asserted and the same access is retried.
REQ-028 The block SHALL have no internal timeout; a responder that never acks keeps the block in WRITE or READ.
REQ-029 The word index SHALL be ceil(log2(N_WORDS+1)) bits wide; i=N_WORDS-1 is the last access, with no wrap-around.

Reset
REQ-030 wb_m.rst=1 at a clock edge SHALL force IDLE from any state, including mid-burst.
REQ-031 On reset, cyc, stb and we SHALL be 0, cti=3'b000, bte=2'b00, adr=0, dat_ms=0 and sel=0.
REQ-032 On reset, busy, done and pass SHALL be 0, err_count=0, first_err_adr=0 and i=0.
REQ-033 No resumption of an interrupted run SHALL occur after reset; a new start is required.

Configuration
REQ-034 Macro MEMTEST_BURST_EN defined: READ SHALL use incrementing bursts with bte=2'b00 linear.
REQ-035 With MEMTEST_BURST_EN defined, each burst SHALL carry cti=3'b010 on every beat except its last, which carries cti=3'b111; cyc/stb stay high across beats.
REQ-036 With MEMTEST_BURST_EN defined, bursts SHALL be BURST_LEN beats; the final burst SHALL be shortened to the words remaining, with cti=3'b111 on word N_WORDS-1.
REQ-037 With MEMTEST_BURST_EN defined, cyc/stb SHALL drop for one cycle between bursts.
REQ-038 Macro MEMTEST_BURST_EN undefined: every read SHALL be a classic cycle with cti=3'b000, and cyc/stb SHALL drop for one cycle after each ack.

Verification
REQ-039 N_WORDS=8 with an ideal 2048-word memory responder: start -> 8 writes then 8 reads; done=1, pass=1, err_count=0, first_err_adr=0.
REQ-040 The responder corrupts bit 0 of word 5 on read: result SHALL be pass=0, err_count=1, first_err_adr=BASE_ADR+20.
REQ-041 MEMTEST_BURST_EN, N_WORDS=10, BURST_LEN=4: reads SHALL run as bursts of 4, 4 and 2 beats, with cti sequence 010,010,010,111 | 010,010,010,111 | 010,111.
REQ-042 The responder asserts err on write i=3: cyc=0 on the next edge, state DONE, pass=0, and no read cycles issued.
REQ-043 Reset asserted during the read of i=2: cyc=stb=0 and busy=done=0 after that edge; a new start reruns from i=0 to pass=1.
REQ-044 All mismatching with N_WORDS=65536: err_count SHALL saturate at 16'hFFFF, and a start pulse issued mid-run SHALL be ignored.
